uart_boot_loader: RTL and testbench



---
 rtl/boot_loader_pkg.sv | 27 ++
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/uart_boot_loader.sv | 142 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: frame and RX state
// encodings, the sync byte, and the word-size helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, half-bit start validation, LSB-first
// shift register, stop-bit check.
// Handshake: rx_valid and rx_ferr are one-cycle pulses with no ready; the
// consumer must take rx_byte in the rx_valid cycle. rx_byte holds until the
// next byte's data bits start shifting in.
module uart_rx_core
  import boot_loader_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr,
  output logic [1:0] state_dbg
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pend_q, pend_d;
  logic          stop_q, stop_d;
  logic          valid_q, ferr_q;

  assign rx_s      = sync_q[1];
  assign rx_valid  = valid_q;
  assign rx_ferr   = ferr_q;
  assign rx_byte   = shift_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pend_d  = 1'b0;
    stop_d  = stop_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // The timer already counts the detect cycle, so it starts at 1.
        if (rx_prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = CW'(1);
        end
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          pend_d  = 1'b1;
          stop_d  = rx_s;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q   <= RX_IDLE;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pend_q    <= 1'b0;
      stop_q    <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], uart_rx_i};
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
      stop_q    <= stop_d;
      valid_q   <= pend_q & stop_q;
      ferr_q    <= pend_q & ~stop_q;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5 | N | N words | XOR checksum frames and writes
// the assembled words sequentially into boot memory.
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int BYTE_LE = 1
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              uart_rx_i,
  input  logic              clear_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              boot_done_o,
  output logic              boot_err_o,
  output logic [2:0]        state_dbg_o,
  output logic [1:0]        rx_state_dbg_o
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;

  logic              rx_valid, rx_ferr;
  logic [7:0]        rx_byte;
  boot_state_t       state_q, state_d;
  logic              start_frame, take_byte, do_write;
  logic              byte_last;
  logic [BW-1:0]     byte_idx_q;
  logic [7:0]        count_q, words_q, xor_q;
  logic [DATA_W-1:0] word_q, word_next, byte_ext;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .uart_rx_i (uart_rx_i),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ferr   (rx_ferr),
    .state_dbg (rx_state_dbg_o)
  );

  assign byte_last = (byte_idx_q == BW'(BPW - 1));
  assign byte_ext  = DATA_W'(rx_byte);
  // Little-endian shifts bytes in from the top so the first lands in [7:0].
  assign word_next = (BYTE_LE != 0) ? ((word_q >> 8) | (byte_ext << (DATA_W - 8)))
                                    : ((word_q << 8) | byte_ext);

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    do_write    = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rx_valid && rx_byte == SYNC_BYTE) state_d = LEN;
        LEN: begin
          if (rx_ferr) state_d = ERR;
          else if (rx_valid) begin
            if (rx_byte == 8'd0 || int'(rx_byte) > DEPTH) state_d = ERR;
            else begin
              state_d     = DATA;
              start_frame = 1'b1;
            end
          end
        end
        DATA: begin
          if (rx_ferr) state_d = ERR;
          else if (rx_valid) begin
            take_byte = 1'b1;
            if (byte_last) begin
              do_write = 1'b1;
              if (words_q + 8'd1 == count_q) state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_ferr) state_d = ERR;
          else if (rx_valid) state_d = (rx_byte == xor_q) ? DONE : ERR;
        end
        DONE, ERR: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      byte_idx_q <= '0;
      count_q    <= '0;
      words_q    <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= do_write;
      if (clear_i || start_frame) begin
        byte_idx_q <= '0;
        words_q    <= '0;
        xor_q      <= '0;
        word_q     <= '0;
      end
      if (start_frame) count_q <= rx_byte;
      if (take_byte) begin
        xor_q      <= xor_q ^ rx_byte;
        word_q     <= word_next;
        byte_idx_q <= byte_last ? '0 : byte_idx_q + 1'b1;
      end
      if (do_write) begin
        addr_q  <= ADDR_W'(words_q);
        wdata_q <= word_next;
        words_q <= words_q + 8'd1;
      end
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign boot_done_o = (state_q == DONE);
  assign boot_err_o  = (state_q == ERR);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: one little-endian and one big-endian instance
// share the RX line; expected memory writes are queued as frames are sent.
`timescale 1ns/1ps
module tb_uart_boot_loader;
  import boot_loader_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int BPW     = DATA_W / 8;
  localparam int ENT_W   = ADDR_W + DATA_W;
  // Edges from the start-bit drive edge to the edge that consumes rx_valid.
  localparam int RXV_LAT = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic              we_le, we_be;
  logic [ADDR_W-1:0] addr_le, addr_be;
  logic [DATA_W-1:0] wd_le, wd_be;
  logic              busy_le, busy_be, done_le, done_be, err_le, err_be;
  logic [2:0]        st_le, st_be;
  logic [1:0]        rxst_le, rxst_be;

  uart_boot_loader #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_LE(1)) dut_le (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx_i(rx), .clear_i(clr),
    .mem_we_o(we_le), .mem_addr_o(addr_le), .mem_wdata_o(wd_le),
    .busy_o(busy_le), .boot_done_o(done_le), .boot_err_o(err_le),
    .state_dbg_o(st_le), .rx_state_dbg_o(rxst_le)
  );

  uart_boot_loader #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_LE(0)) dut_be (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx_i(rx), .clear_i(clr),
    .mem_we_o(we_be), .mem_addr_o(addr_be), .mem_wdata_o(wd_be),
    .busy_o(busy_be), .boot_done_o(done_be), .boot_err_o(err_be),
    .state_dbg_o(st_be), .rx_state_dbg_o(rxst_be)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] exp_le_q[$];
  logic [ENT_W-1:0] exp_be_q[$];
  logic prev_we_le = 1'b0;
  logic prev_we_be = 1'b0;

  always @(negedge clk) begin
    if (we_le) begin
      check_eq("le_write_expected", 64'(exp_le_q.size() != 0), 64'd1);
      if (exp_le_q.size() != 0) check_eq("le_write", {addr_le, wd_le}, exp_le_q.pop_front());
      check_eq("le_we_single", prev_we_le, 0);
    end
    if (we_be) begin
      check_eq("be_write_expected", 64'(exp_be_q.size() != 0), 64'd1);
      if (exp_be_q.size() != 0) check_eq("be_write", {addr_be, wd_be}, exp_be_q.pop_front());
      check_eq("be_we_single", prev_we_be, 0);
    end
    prev_we_le = we_le;
    prev_we_be = we_be;
  end

  task automatic check_flags(input string tag, input logic b, input logic d, input logic e,
                             input logic [2:0] s);
    check_eq({tag, "_busy"}, {busy_be, busy_le}, {b, b});
    check_eq({tag, "_done"}, {done_be, done_le}, {d, d});
    check_eq({tag, "_err"}, {err_be, err_le}, {e, e});
    check_eq({tag, "_state"}, {st_be, st_le}, {s, s});
    check_eq({tag, "_rx_idle"}, {rxst_be, rxst_le}, {RX_IDLE, RX_IDLE});
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_le_pending"}, exp_le_q.size(), 0);
    check_eq({tag, "_be_pending"}, exp_be_q.size(), 0);
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(CLK_DIV);
      rx = b[i];
    end
    idle(CLK_DIV);
    rx = stop_bit;
    idle(CLK_DIV);
    rx = 1'b1;
  endtask

  task automatic glitch();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  logic [7:0] pl_q[$];

  // Sends A5 | n | pl_q | checksum. Words completed before ferr_idx are expected.
  task automatic send_frame(input logic [7:0] n, input logic flip_csum, input int ferr_idx,
                            input logic glitch_in_len);
    logic [7:0]        x;
    logic [DATA_W-1:0] le, be;
    x  = 8'h00;
    le = '0;
    be = '0;
    for (int w = 0; w < pl_q.size() / BPW; w++) begin
      if (ferr_idx < 0 || (w + 1) * BPW <= ferr_idx) begin
        for (int j = 0; j < BPW; j++) begin
          le[8*j +: 8]           = pl_q[w*BPW + j];
          be[8*(BPW-1-j) +: 8]   = pl_q[w*BPW + j];
        end
        exp_le_q.push_back({ADDR_W'(w), le});
        exp_be_q.push_back({ADDR_W'(w), be});
      end
    end
    send_byte(8'hA5, 1'b1);
    if (glitch_in_len) begin
      idle(2);
      check_flags("len", 1'b1, 1'b0, 1'b0, LEN);
      glitch();
      idle(12 * CLK_DIV);
      check_flags("len_glitch", 1'b1, 1'b0, 1'b0, LEN);
    end
    send_byte(n, 1'b1);
    for (int i = 0; i < pl_q.size(); i++) begin
      if (i == ferr_idx) begin
        send_byte(pl_q[i], 1'b0);
        return;
      end
      send_byte(pl_q[i], 1'b1);
      x ^= pl_q[i];
    end
    send_byte(flip_csum ? ~x : x, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_eq("rst_outputs_le", {we_le, addr_le, wd_le, busy_le, done_le, err_le}, 0);
    check_eq("rst_outputs_be", {we_be, addr_be, wd_be, busy_be, done_be, err_be}, 0);
    rst = 1'b0;
    idle(2);
    check_flags("post_reset", 1'b0, 1'b0, 1'b0, IDLE);

    // Good two-word frame.
    pl_q = '{8'h37, 8'h00, 8'h00, 8'h20, 8'h93, 8'h00, 8'h40, 8'h00};
    send_frame(8'h02, 1'b0, -1, 1'b0);
    idle(2);
    check_flags("good", 1'b0, 1'b1, 1'b0, DONE);
    check_drained("good");
    check_eq("good_addr_hold", addr_le, 1);
    check_eq("good_le_word1", wd_le, 32'h0040_0093);
    check_eq("good_be_word1", wd_be, 32'h9300_4000);
    pulse_clear();
    check_flags("good_clr", 1'b0, 1'b0, 1'b0, IDLE);

    // Inverted checksum: writes still happen, then error.
    send_frame(8'h02, 1'b1, -1, 1'b0);
    idle(2);
    check_flags("bad_csum", 1'b0, 1'b0, 1'b1, ERR);
    check_drained("bad_csum");
    pulse_clear();
    check_flags("bad_csum_clr", 1'b0, 1'b0, 1'b0, IDLE);

    // Count out of range and zero count.
    pl_q = {};
    send_frame(8'h11, 1'b0, -1, 1'b0);
    idle(2);
    check_flags("cnt_11", 1'b0, 1'b0, 1'b1, ERR);
    pulse_clear();
    send_frame(8'h00, 1'b0, -1, 1'b0);
    idle(2);
    check_flags("cnt_00", 1'b0, 1'b0, 1'b1, ERR);
    pulse_clear();
    check_flags("cnt_clr", 1'b0, 1'b0, 1'b0, IDLE);

    // Framing error on the third payload byte: no write.
    pl_q = '{8'h37, 8'h00, 8'h00, 8'h20, 8'h93, 8'h00, 8'h40, 8'h00};
    send_frame(8'h02, 1'b0, 2, 1'b0);
    idle(2);
    check_flags("ferr", 1'b0, 1'b0, 1'b1, ERR);
    check_drained("ferr");
    pulse_clear();

    // Short glitch while idle.
    glitch();
    idle(12 * CLK_DIV);
    check_flags("idle_glitch", 1'b0, 1'b0, 1'b0, IDLE);

    // Noise bytes, then a one-word frame with a glitch while in LEN.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    idle(2);
    check_flags("noise", 1'b0, 1'b0, 1'b0, IDLE);
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'h01, 1'b0, -1, 1'b1);
    idle(2);
    check_flags("noise_frame", 1'b0, 1'b1, 1'b0, DONE);
    check_drained("noise_frame");
    check_eq("noise_le_word", wd_le, 32'h0403_0201);
    check_eq("noise_be_word", wd_be, 32'h0102_0304);
    pulse_clear();

    // clear_i in the same cycle as the sync byte's rx_valid.
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (RXV_LAT) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
      end
    join
    idle(2);
    check_flags("clr_coinc", 1'b0, 1'b0, 1'b0, IDLE);
    send_byte(8'h02, 1'b1);
    idle(2);
    check_flags("clr_coinc_after", 1'b0, 1'b0, 1'b0, IDLE);

    // Asynchronous reset mid-DATA after one word, then a clean load.
    exp_le_q.push_back({4'd0, 32'h2000_0037});
    exp_be_q.push_back({4'd0, 32'h3700_0020});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h37, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h93, 1'b1);
    idle(2);
    check_eq("mid_data_busy", {busy_be, busy_le}, 2'b11);
    rst = 1'b1;
    #2;
    check_eq("async_rst_le", {we_le, addr_le, wd_le, busy_le, done_le, err_le}, 0);
    check_eq("async_rst_be", {we_be, addr_be, wd_be, busy_be, done_be, err_be}, 0);
    idle(3);
    rst = 1'b0;
    idle(3);
    check_flags("after_rst", 1'b0, 1'b0, 1'b0, IDLE);
    check_drained("after_rst");
    pl_q = '{8'h37, 8'h00, 8'h00, 8'h20, 8'h93, 8'h00, 8'h40, 8'h00};
    send_frame(8'h02, 1'b0, -1, 1'b0);
    idle(2);
    check_flags("reload", 1'b0, 1'b1, 1'b0, DONE);
    check_drained("reload");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
